// File: rtl/gauss_conv5x5_stream.sv
`default_nettype none
// ============================================================================
//  Module      : gauss_conv5x5_stream
//  Description : Streaming 5x5 symmetric convolution, zero padded, same-size
//                output. Four line buffers and a 5x5 window register array.
//                Valid/ready handshake on both sides. Output is rounded and
//                saturated. Six programmable coefficient classes and a bypass
//                mode are provided.
//  Revision    : 1.0 - initial release
// ============================================================================
module gauss_conv5x5_stream #(
  parameter int DW        = 8,
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 480,
  parameter int COEF_W    = 8,
  parameter int COEF_FRAC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic              m_last,
  input  logic              cfg_bypass,
  input  logic              coef_we,
  input  logic [2:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              busy
);

  localparam int c_sum_w      = DW + COEF_W + 5;
  localparam int c_xw         = $clog2(IMG_W);
  localparam int c_yw         = $clog2(IMG_H);
  localparam int c_nw         = $clog2(IMG_W * IMG_H + 1);
  localparam int c_fill_last  = 2 * IMG_W + 1;
  localparam int c_frame_last = IMG_W * IMG_H - 1;
  localparam int c_round      = (COEF_FRAC > 0) ? (1 << (COEF_FRAC - 1)) : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_run;
  logic                r_bypass;
  logic [c_nw-1:0]     r_n;
  logic [c_xw-1:0]     r_col;
  logic [c_xw-1:0]     r_ox;
  logic [c_yw-1:0]     r_oy;
  logic [COEF_W-1:0]   r_coef [6];
  logic                r_m_valid;
  logic [DW-1:0]       r_m_data;
  logic                r_m_last;
  logic [DW-1:0]       r_lb   [4][IMG_W];
  logic [DW-1:0]       r_win  [5][5];

  logic                w_free;
  logic                w_step;
  logic                w_emit;
  logic                w_last_out;
  logic [DW-1:0]       w_pix;
  logic [c_xw-1:0]     w_col_inc;
  logic [DW-1:0]       w_col_new  [5];
  logic [DW-1:0]       w_win_next [5][5];
  logic [4:0]          w_row_ok;
  logic [4:0]          w_col_ok;
  logic [c_sum_w-1:0]  w_sum;
  logic [c_sum_w-1:0]  w_shift;
  logic [DW-1:0]       w_filt;

  // Coefficient class of window tap (i,j); centre of the window is (2,2).
  function automatic logic [2:0] tap_class(input int i, input int j);
    int ady;
    int adx;
    ady = (i > 2) ? i - 2 : 2 - i;
    adx = (j > 2) ? j - 2 : 2 - j;
    if (ady == 2 && adx == 2)      return 3'd0;
    else if (ady + adx == 3)       return 3'd1;
    else if (ady + adx == 2 && ady != 1) return 3'd2;
    else if (ady == 1 && adx == 1) return 3'd3;
    else if (ady + adx == 1)       return 3'd4;
    else                           return 3'd5;
  endfunction

  // Handshake: a step needs a free output register; FLUSH steps need no input.
  assign w_free     = !r_m_valid || m_ready;
  assign w_step     = w_free && r_run && ((r_state == S_FLUSH) || s_valid);
  assign w_emit     = w_step && ((r_state == S_RUN) || (r_state == S_FLUSH));
  assign w_pix      = (r_state == S_FLUSH) ? '0 : s_data;
  assign w_col_inc  = (r_col == c_xw'(IMG_W - 1)) ? '0 : r_col + 1'b1;
  assign w_last_out = (r_ox == c_xw'(IMG_W - 1)) && (r_oy == c_yw'(IMG_H - 1));
  assign s_ready    = r_run && w_free && (r_state != S_FLUSH);
  assign busy       = (r_state != S_IDLE);
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;

  // New column vector: row 4 is the incoming pixel, rows 3..0 come from the line buffers.
  always_comb begin
    w_col_new[4] = w_pix;
    for (int k = 0; k < 4; k++) begin
      w_col_new[3-k] = r_lb[k][r_col];
    end
  end

  // Window after this step: shift columns left, append the new column on the right.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        w_win_next[i][j] = (j < 4) ? r_win[i][j+1] : w_col_new[i];
      end
    end
  end

  // Tap validity from the centre position; stale data across row ends or frames is masked.
  always_comb begin
    w_row_ok[0] = (r_oy >= c_yw'(2));
    w_row_ok[1] = (r_oy >= c_yw'(1));
    w_row_ok[2] = 1'b1;
    w_row_ok[3] = (r_oy <= c_yw'(IMG_H - 2));
    w_row_ok[4] = (r_oy <= c_yw'(IMG_H - 3));
    w_col_ok[0] = (r_ox >= c_xw'(2));
    w_col_ok[1] = (r_ox >= c_xw'(1));
    w_col_ok[2] = 1'b1;
    w_col_ok[3] = (r_ox <= c_xw'(IMG_W - 2));
    w_col_ok[4] = (r_ox <= c_xw'(IMG_W - 3));
  end

  // Multiply-accumulate over the masked window, then round and saturate.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        if (w_row_ok[i] && w_col_ok[j]) begin
          w_sum = w_sum + c_sum_w'(w_win_next[i][j]) * c_sum_w'(r_coef[tap_class(i, j)]);
        end
      end
    end
    w_shift = (w_sum + c_sum_w'(c_round)) >> COEF_FRAC;
    w_filt  = (|w_shift[c_sum_w-1:DW]) ? '1 : w_shift[DW-1:0];
  end

  // Line buffers and window registers advance on every step; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_step) begin
      r_lb[0][r_col] <= w_pix;
      for (int k = 1; k < 4; k++) begin
        r_lb[k][r_col] <= r_lb[k-1][r_col];
      end
      r_win <= w_win_next;
    end
  end

  // Coefficient registers: writable only while idle, indices above 5 dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coef[0] <= COEF_W'(1);
      r_coef[1] <= COEF_W'(3);
      r_coef[2] <= COEF_W'(6);
      r_coef[3] <= COEF_W'(15);
      r_coef[4] <= COEF_W'(25);
      r_coef[5] <= COEF_W'(41);
    end else if (coef_we && (r_state == S_IDLE) && (coef_addr <= 3'd5)) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end

  // Output register: loaded on an emitting step, cleared once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_emit) begin
      r_m_valid <= 1'b1;
      r_m_data  <= r_bypass ? w_win_next[2][2] : w_filt;
      r_m_last  <= w_last_out;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end
  end

  // Frame sequencer: input/output position counters and IDLE/FILL/RUN/FLUSH control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_run    <= 1'b0;
      r_bypass <= 1'b0;
      r_n      <= '0;
      r_col    <= '0;
      r_ox     <= '0;
      r_oy     <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_step) begin
        r_col <= w_col_inc;
        if (w_emit) begin
          if (r_ox == c_xw'(IMG_W - 1)) begin
            r_ox <= '0;
            r_oy <= r_oy + 1'b1;
          end else begin
            r_ox <= r_ox + 1'b1;
          end
        end
        case (r_state)
          S_IDLE: begin
            r_state  <= S_FILL;
            r_bypass <= cfg_bypass;
            r_n      <= c_nw'(1);
            r_ox     <= '0;
            r_oy     <= '0;
          end
          S_FILL: begin
            r_n <= r_n + 1'b1;
            if (r_n == c_nw'(c_fill_last)) r_state <= S_RUN;
          end
          S_RUN: begin
            r_n <= r_n + 1'b1;
            if (r_n == c_nw'(c_frame_last)) r_state <= S_FLUSH;
          end
          S_FLUSH: begin
            if (w_last_out) begin
              r_state <= S_IDLE;
              r_n     <= '0;
              r_col   <= '0;
              r_ox    <= '0;
              r_oy    <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
